// File: rtl/mem_arb_pkg.sv
// Shared encodings for the three-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] owner_t;

  // Owner codes double as bit positions in the one-hot winner vector.
  localparam owner_t OWN_I    = 2'd0;
  localparam owner_t OWN_D    = 2'd1;
  localparam owner_t OWN_X    = 2'd2;
  localparam owner_t OWN_NONE = 2'd3;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority pick (d > i > x) with a starvation override that puts x first.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       x_req,
  input  logic       starve,
  output logic [2:0] winner
);

  always_comb begin
    winner = '0;
    if (x_req && starve) begin
      winner[OWN_X] = 1'b1;
    end else if (d_req) begin
      winner[OWN_D] = 1'b1;
    end else if (i_req) begin
      winner[OWN_I] = 1'b1;
    end else if (x_req) begin
      winner[OWN_X] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (i), data (d) and debug (x)
// requesters, one transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  parameter int AGE_W      = 3
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  input  logic        x_req,
  input  logic        x_we,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_wdata,
  output logic        x_gnt,
  output logic        x_rvalid,
  output logic [31:0] r_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [2:0]       winner;
  logic             starve;

  assign starve = ({{(32-AGE_W){1'b0}}, age_q} >= 32'(STARVE_MAX));

  mem_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .x_req  (x_req),
    .starve (starve),
    .winner (winner)
  );

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      age_q   <= age_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    age_d   = age_q;
    unique case (state_q)
      IDLE: begin
        // x ages only on cycles where it asked and someone else won.
        if (winner[OWN_X]) begin
          age_d = '0;
        end else if (x_req && (age_q != '1)) begin
          age_d = age_q + AGE_W'(1);
        end
        if (|winner) begin
          state_d = ISSUE;
          if (winner[OWN_D]) begin
            owner_d = OWN_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else if (winner[OWN_I]) begin
            owner_d = OWN_I;
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            owner_d = OWN_X;
            addr_d  = x_addr;
            we_d    = x_we;
            wdata_d = x_wdata;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = we_q ? '0 : m_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants are masked while Clrn is low so nothing is offered during reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    x_gnt = 1'b0;
    if ((state_q == IDLE) && Clrn) begin
      i_gnt = winner[OWN_I];
      d_gnt = winner[OWN_D];
      x_gnt = winner[OWN_X];
    end
    i_rvalid = (state_q == DONE) && (owner_q == OWN_I);
    d_rvalid = (state_q == DONE) && (owner_q == OWN_D);
    x_rvalid = (state_q == DONE) && (owner_q == OWN_X);
  end

  assign m_en    = (state_q == ISSUE);
  assign m_we    = m_en & we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign r_rdata = rdata_q;

endmodule
